mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencing controller and two-port arbiter in front of the 256×8 byte-addressed RAM. Shares the single RAM port between the instruction-fetch unit and the load/store unit. Drives the RAM's MOV/ReadWrite/Address/DataType/SIGN strobes, waits for MOC, latches read data, and flags misalignment and timeouts. Splits doubleword requests into two word transfers.

## Interface
- TIMEOUT, 15: maximum WAIT cycles without MOC before the access aborts with an error (1..255).

- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- IReq  in  1  fetch request; held until IAck
- IAddr  in  8  fetch byte address; always a word read
- IAck  out  1  one-cycle completion pulse, fetch port
- IErr  out  1  valid with IAck; misaligned address or timeout
- IData  out  32  fetched word; valid with IAck, held until the next fetch
- DReq  in  1  data request; held until DAck
- DRW  in  1  1 = load, 0 = store (same sense as RAM ReadWrite)
- DAddr  in  8  data byte address
- DType  in  2  00 byte, 01 half, 10 word, 11 doubleword
- DSign  in  1  sign-extend byte/half loads
- DWrData  in  64  store data; [31:0] to DAddr, [63:32] to DAddr+4
- DAck  out  1  one-cycle completion pulse, data port
- DErr  out  1  valid with DAck
- DRdData  out  64  load data, same lane mapping; [63:32]=0 unless doubleword
- Busy  out  1  high in every state except IDLE
- MemMOV  out  1  RAM MOV
- MemRW  out  1  RAM ReadWrite
- MemAddr  out  8  RAM Address
- MemDataIn  out  32  RAM DataIn
- MemType  out  2  RAM DataType
- MemSign  out  1  RAM SIGN
- MemDataOut  in  32  RAM DataOut
- MemMOC  in  1  RAM MOC

## Operation
- States: IDLE, SETUP, STROBE, WAIT, DONE.
- IDLE: arbitrate among pending requests.
  - Only one request pending: grant it.
  - Both pending: round-robin on the LastGrant bit (reset value = fetch, so data wins the first tie).
  - Requests are latched at grant; later changes to the requester's inputs are ignored.
- Alignment check at grant: half requires Addr[0]=0; word and doubleword require Addr[1:0]=0.
  - Misaligned: go directly to DONE with Err=1 and read data 0. No RAM strobe is issued.
- SETUP: MemMOV=0. Drive MemAddr, MemRW, MemDataIn, MemType, MemSign from the latched request.
  - Fetch: MemType=10, MemSign=0.
  - Doubleword: MemType=10 for each half.
- STROBE: MemMOV=1. Address, RW and data stay stable.
- WAIT: MemMOV stays 1.
  - Sample MemMOC each cycle; the first sample is in the first WAIT cycle.
  - MemMOC=1 on a load: capture MemDataOut into the active read lane.
  - After capture: single access → DONE; first doubleword half → SETUP with MemAddr+4 (mod 256) and DWrData[63:32]; second half → DONE.
  - Wait counter reaches TIMEOUT: go to DONE with Err=1.
- DONE: MemMOV=0. Pulse the granted port's Ack for one cycle with Err and read data valid. Update LastGrant. Return to IDLE.
- Address arithmetic wraps modulo 256: a doubleword at 0xFC uses 0xFC then 0x00, with no error.
- MemAddr, MemRW, MemDataIn, MemType and MemSign change only while MemMOV=0.

## Timing
- Reset values:
  - All outputs 0, except MemRW=1.
  - State IDLE, LastGrant = fetch, wait counter 0.
  - IData and DRdData cleared.
- Reset mid-operation: MemMOV drops immediately (asynchronous). The in-flight access is abandoned with no Ack. Requesters must keep Req asserted to retry.
- Single access with MemMOC already high: Req sampled in IDLE at edge 0 → SETUP e1, STROBE e2, WAIT e3, DONE e4. Ack is high for the cycle after e4 (latency 4 edges).
- Doubleword: Ack after e7. Each extra WAIT cycle adds one edge.
- Misaligned: Ack after e1.
- Timeout: Ack after e(2+TIMEOUT).
- Back-to-back: a Req still pending at DONE is arbitrated at the next IDLE edge. Turnaround is one IDLE cycle minimum.

## Test plan
- Fetch only, IAddr=0x10, RAM holds 0xDEADBEEF at 0x10 → IAck after e4, IData=0xDEADBEEF, IErr=0, MemType=10.
- Byte load, DAddr=0x21 holds 0x80, DSign=1 → DRdData=0x00000000FFFFFF80. Same access with DSign=0 → 0x0000000000000080.
- Doubleword store of 0x1122334455667788 at 0xFC, then doubleword load from 0xFC → MemAddr sequence 0xFC, 0x00. Load returns the same 64-bit value. Ack after e7.
- IReq and DReq both asserted from reset → data granted first, fetch second. Acks 5 edges apart (4-cycle access plus one IDLE cycle).
- Half load at DAddr=0x31 → DAck after e1, DErr=1, MemMOV never rises.
- MemMOC held at 0 with TIMEOUT=3 → DErr at e5. Separately, Reset pulsed while in STROBE → MemMOV=0 immediately and no Ack occurs.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Arbitrates fetch and load/store ports onto one RAM port; access takes 4 edges, +3 per extra dword half, +1 per extra WAIT.
// Requesters hold Req until their one-cycle Ack; the loser of a tie waits in IDLE until the port frees.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        IReq,
   input  logic [7:0]  IAddr,
   output logic        IAck,
   output logic        IErr,
   output logic [31:0] IData,
   input  logic        DReq,
   input  logic        DRW,
   input  logic [7:0]  DAddr,
   input  logic [1:0]  DType,
   input  logic        DSign,
   input  logic [63:0] DWrData,
   output logic        DAck,
   output logic        DErr,
   output logic [63:0] DRdData,
   output logic        Busy,
   output logic        MemMOV,
   output logic        MemRW,
   output logic [7:0]  MemAddr,
   output logic [31:0] MemDataIn,
   output logic [1:0]  MemType,
   output logic        MemSign,
   input  logic [31:0] MemDataOut,
   input  logic        MemMOC
);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_DONE} state_t;

   localparam logic [8:0] TO9 = 9'(TIMEOUT);

   state_t      state_q, state_d;
   logic        last_data_q;
   logic        gnt_data_q;
   logic        rw_q;
   logic [7:0]  addr_q;
   logic [1:0]  type_q;
   logic        sign_q;
   logic [63:0] wdata_q;
   logic        dword_q;
   logic        half_q;
   logic        err_q;
   logic [63:0] rdata_q;
   logic [7:0]  cnt_q, cnt_d;
   logic        iack_q, ierr_q, dack_q, derr_q;
   logic [31:0] idata_q;
   logic [63:0] drdata_q;

   logic        ireq_e, dreq_e, any_req, pick_data, misalign;
   logic [8:0]  cnt_inc;
   logic        timeout_hit, last_half;
   logic        mem_mov, busy;

   // A port whose Ack is showing still has Req high this cycle; it must not be re-granted.
   assign ireq_e    = IReq & ~iack_q;
   assign dreq_e    = DReq & ~dack_q;
   assign any_req   = ireq_e | dreq_e;
   assign pick_data = dreq_e & (~ireq_e | ~last_data_q);

   always_comb begin
      misalign = 1'b0;
      if (pick_data) begin
         if (DType == 2'b01)
            misalign = DAddr[0];
         else if (DType[1])
            misalign = |DAddr[1:0];
      end else begin
         misalign = |IAddr[1:0];
      end
   end

   // The counter already holds 1 on entering WAIT: the STROBE cycle counts toward the budget.
   assign cnt_inc     = {1'b0, cnt_q} + 9'd1;
   assign timeout_hit = (cnt_inc >= TO9);
   assign last_half   = ~dword_q | half_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (any_req) state_d = misalign ? S_DONE : S_SETUP;
         S_SETUP:  state_d = S_STROBE;
         S_STROBE: state_d = S_WAIT;
         S_WAIT: begin
            if (MemMOC)
               state_d = last_half ? S_DONE : S_SETUP;
            else if (timeout_hit)
               state_d = S_DONE;
         end
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = 8'd0;
      case (state_q)
         S_STROBE: cnt_d = 8'd1;
         S_WAIT:   cnt_d = cnt_inc[7:0];
         default:  cnt_d = 8'd0;
      endcase
   end

   always_comb begin
      mem_mov = 1'b0;
      busy    = (state_q != S_IDLE);
      if (state_q == S_STROBE || state_q == S_WAIT)
         mem_mov = 1'b1;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         last_data_q <= 1'b0;
         gnt_data_q  <= 1'b0;
         rw_q        <= 1'b1;
         addr_q      <= 8'd0;
         type_q      <= 2'b00;
         sign_q      <= 1'b0;
         wdata_q     <= 64'd0;
         dword_q     <= 1'b0;
         half_q      <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= 64'd0;
         iack_q      <= 1'b0;
         ierr_q      <= 1'b0;
         dack_q      <= 1'b0;
         derr_q      <= 1'b0;
         idata_q     <= 32'd0;
         drdata_q    <= 64'd0;
      end else begin
         iack_q <= 1'b0;
         ierr_q <= 1'b0;
         dack_q <= 1'b0;
         derr_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  gnt_data_q <= pick_data;
                  err_q      <= misalign;
                  rdata_q    <= 64'd0;
                  half_q     <= 1'b0;
                  if (pick_data) begin
                     rw_q    <= DRW;
                     addr_q  <= DAddr;
                     type_q  <= (DType == 2'b11) ? 2'b10 : DType;
                     sign_q  <= DSign;
                     wdata_q <= DWrData;
                     dword_q <= (DType == 2'b11);
                  end else begin
                     rw_q    <= 1'b1;
                     addr_q  <= IAddr;
                     type_q  <= 2'b10;
                     sign_q  <= 1'b0;
                     wdata_q <= 64'd0;
                     dword_q <= 1'b0;
                  end
               end
            end
            S_WAIT: begin
               if (MemMOC) begin
                  if (rw_q) begin
                     if (half_q)
                        rdata_q[63:32] <= MemDataOut;
                     else
                        rdata_q[31:0] <= MemDataOut;
                  end
                  if (!last_half) begin
                     half_q <= 1'b1;
                     addr_q <= addr_q + 8'd4;
                  end
               end else if (timeout_hit) begin
                  err_q <= 1'b1;
               end
            end
            S_DONE: begin
               last_data_q <= gnt_data_q;
               if (gnt_data_q) begin
                  dack_q <= 1'b1;
                  derr_q <= err_q;
                  if (rw_q)
                     drdata_q <= rdata_q;
               end else begin
                  iack_q  <= 1'b1;
                  ierr_q  <= err_q;
                  idata_q <= rdata_q[31:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign IAck      = iack_q;
   assign IErr      = ierr_q;
   assign IData     = idata_q;
   assign DAck      = dack_q;
   assign DErr      = derr_q;
   assign DRdData   = drdata_q;
   assign Busy      = busy;
   assign MemMOV    = mem_mov;
   assign MemRW     = rw_q;
   assign MemAddr   = addr_q;
   assign MemDataIn = half_q ? wdata_q[63:32] : wdata_q[31:0];
   assign MemType   = type_q;
   assign MemSign   = sign_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 256x8 RAM and an ack scoreboard.
module tb_mem_access_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        IReq;
   logic [7:0]  IAddr;
   logic        IAck, IErr;
   logic [31:0] IData;
   logic        DReq, DRW, DSign;
   logic [7:0]  DAddr;
   logic [1:0]  DType;
   logic [63:0] DWrData;
   logic        DAck, DErr;
   logic [63:0] DRdData;
   logic        Busy, MemMOV, MemRW, MemSign, MemMOC;
   logic [7:0]  MemAddr;
   logic [31:0] MemDataIn, MemDataOut;
   logic [1:0]  MemType;

   always #5 Clk = ~Clk;

   mem_access_ctrl #(.TIMEOUT(3)) dut (
      .Clk(Clk), .Reset(Reset),
      .IReq(IReq), .IAddr(IAddr), .IAck(IAck), .IErr(IErr), .IData(IData),
      .DReq(DReq), .DRW(DRW), .DAddr(DAddr), .DType(DType), .DSign(DSign),
      .DWrData(DWrData), .DAck(DAck), .DErr(DErr), .DRdData(DRdData),
      .Busy(Busy), .MemMOV(MemMOV), .MemRW(MemRW), .MemAddr(MemAddr),
      .MemDataIn(MemDataIn), .MemType(MemType), .MemSign(MemSign),
      .MemDataOut(MemDataOut), .MemMOC(MemMOC)
   );

   // Behavioural RAM, big-endian within a word; MOC after moc_lat cycles of MOV.
   logic [7:0] mem [0:255] = '{default: 8'h00};
   logic       moc_en;
   int         moc_lat;
   int         mov_cnt = 0;

   always @(posedge Clk) mov_cnt <= MemMOV ? mov_cnt + 1 : 0;
   assign MemMOC = MemMOV && moc_en && (mov_cnt >= moc_lat);

   always_comb begin
      case (MemType)
         2'b00:   MemDataOut = {{24{MemSign & mem[MemAddr][7]}}, mem[MemAddr]};
         2'b01:   MemDataOut = {{16{MemSign & mem[MemAddr][7]}}, mem[MemAddr], mem[MemAddr + 8'd1]};
         default: MemDataOut = {mem[MemAddr], mem[MemAddr + 8'd1], mem[MemAddr + 8'd2], mem[MemAddr + 8'd3]};
      endcase
   end

   always @(posedge Clk) begin
      if (MemMOV && MemMOC && !MemRW) begin
         case (MemType)
            2'b00: mem[MemAddr] <= MemDataIn[7:0];
            2'b01: begin
               mem[MemAddr]        <= MemDataIn[15:8];
               mem[MemAddr + 8'd1] <= MemDataIn[7:0];
            end
            default: begin
               mem[MemAddr]        <= MemDataIn[31:24];
               mem[MemAddr + 8'd1] <= MemDataIn[23:16];
               mem[MemAddr + 8'd2] <= MemDataIn[15:8];
               mem[MemAddr + 8'd3] <= MemDataIn[7:0];
            end
         endcase
      end
   end

   typedef struct {
      int          id;
      bit          err;
      bit          chk;
      logic [63:0] data;
      int          cyc;
   } exp_t;

   exp_t        dq[$];
   exp_t        iq[$];
   logic [7:0]  alog[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          dack_cnt = 0;
   int          iack_cnt = 0;
   int          mov_rises = 0;
   logic        mov_prev = 1'b0;
   logic [43:0] bus_prev = '0;
   logic [1:0]  last_type = 2'b00;
   logic        last_sign = 1'b0;

   task automatic chk(input string tag, input int id, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s #%0d got %h expected %h", tag, id, got, exp);
      end
   endtask

   task automatic observe();
      exp_t e;
      cyc++;
      if (DAck) begin
         dack_cnt++;
         DReq = 1'b0;
         chk("dack_expected", cyc, 64'(dq.size() > 0), 64'd1);
         if (dq.size() > 0) begin
            e = dq.pop_front();
            chk("dack_cycle", e.id, 64'(cyc), 64'(e.cyc));
            chk("derr", e.id, 64'(DErr), 64'(e.err));
            if (e.chk) chk("drdata", e.id, DRdData, e.data);
         end
      end
      if (IAck) begin
         iack_cnt++;
         IReq = 1'b0;
         chk("iack_expected", cyc, 64'(iq.size() > 0), 64'd1);
         if (iq.size() > 0) begin
            e = iq.pop_front();
            chk("iack_cycle", e.id, 64'(cyc), 64'(e.cyc));
            chk("ierr", e.id, 64'(IErr), 64'(e.err));
            if (e.chk) chk("idata", e.id, 64'(IData), e.data);
         end
      end
      if (MemMOV && !mov_prev) begin
         mov_rises++;
         alog.push_back(MemAddr);
         last_type = MemType;
         last_sign = MemSign;
      end else if (MemMOV && mov_prev) begin
         chk("bus_stable", cyc, 64'({MemAddr, MemRW, MemDataIn, MemType, MemSign}), 64'(bus_prev));
      end
      mov_prev = MemMOV;
      bus_prev = {MemAddr, MemRW, MemDataIn, MemType, MemSign};
   endtask

   task automatic tick();
      @(negedge Clk);
      observe();
   endtask

   // lat = edges from the granting edge to the edge after which Ack is visible
   task automatic issue_d(input int id, input logic rw, input logic [7:0] addr, input logic [1:0] typ,
                          input logic sgn, input logic [63:0] wdata, input bit err, input bit chkd,
                          input logic [63:0] data, input int lat);
      exp_t e;
      DReq = 1'b1; DRW = rw; DAddr = addr; DType = typ; DSign = sgn; DWrData = wdata;
      e.id = id; e.err = err; e.chk = chkd; e.data = data; e.cyc = cyc + 1 + lat;
      dq.push_back(e);
   endtask

   task automatic issue_i(input int id, input logic [7:0] addr, input bit err, input logic [63:0] data,
                          input int lat);
      exp_t e;
      IReq = 1'b1; IAddr = addr;
      e.id = id; e.err = err; e.chk = 1'b1; e.data = data; e.cyc = cyc + 1 + lat;
      iq.push_back(e);
   endtask

   task automatic wait_acks(input int id, input int n);
      int target = dack_cnt + iack_cnt + n;
      int b = 0;
      while ((dack_cnt + iack_cnt) < target && b < 60) begin
         tick();
         b++;
      end
      chk("ack_arrived", id, 64'((dack_cnt + iack_cnt) >= target), 64'd1);
   endtask

   initial begin
      int rises0;
      int acks0;
      Reset = 1'b1; IReq = 1'b0; IAddr = 8'h00; DReq = 1'b0; DRW = 1'b1; DAddr = 8'h00;
      DType = 2'b00; DSign = 1'b0; DWrData = 64'd0; moc_en = 1'b1; moc_lat = 0;
      repeat (2) tick();

      chk("rst_iack", 0, 64'(IAck), 64'd0);
      chk("rst_ierr", 0, 64'(IErr), 64'd0);
      chk("rst_idata", 0, 64'(IData), 64'd0);
      chk("rst_dack", 0, 64'(DAck), 64'd0);
      chk("rst_derr", 0, 64'(DErr), 64'd0);
      chk("rst_drdata", 0, DRdData, 64'd0);
      chk("rst_busy", 0, 64'(Busy), 64'd0);
      chk("rst_mov", 0, 64'(MemMOV), 64'd0);
      chk("rst_rw", 0, 64'(MemRW), 64'd1);
      chk("rst_addr", 0, 64'(MemAddr), 64'd0);
      chk("rst_datain", 0, 64'(MemDataIn), 64'd0);
      chk("rst_type", 0, 64'(MemType), 64'd0);
      chk("rst_sign", 0, 64'(MemSign), 64'd0);
      Reset = 1'b0;

      tick(); issue_d(1, 1'b0, 8'h10, 2'b10, 1'b0, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0, 64'd0, 4);
      wait_acks(1, 1);
      tick(); issue_i(2, 8'h10, 1'b0, 64'h0000_0000_DEAD_BEEF, 4);
      wait_acks(2, 1);
      chk("fetch_type", 2, 64'(last_type), 64'd2);
      chk("fetch_sign", 2, 64'(last_sign), 64'd0);

      tick(); issue_d(3, 1'b0, 8'h21, 2'b00, 1'b0, 64'h0000_0000_0000_0080, 1'b0, 1'b0, 64'd0, 4);
      wait_acks(3, 1);
      tick(); issue_d(4, 1'b1, 8'h21, 2'b00, 1'b1, 64'd0, 1'b0, 1'b1, 64'h0000_0000_FFFF_FF80, 4);
      wait_acks(4, 1);
      tick(); issue_d(5, 1'b1, 8'h21, 2'b00, 1'b0, 64'd0, 1'b0, 1'b1, 64'h0000_0000_0000_0080, 4);
      wait_acks(5, 1);

      alog.delete();
      tick(); issue_d(6, 1'b0, 8'hFC, 2'b11, 1'b0, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 64'd0, 7);
      wait_acks(6, 1);
      chk("dws_nstrobes", 6, 64'(alog.size()), 64'd2);
      chk("dws_addr0", 6, 64'(alog[0]), 64'hFC);
      chk("dws_addr1", 6, 64'(alog[1]), 64'h00);
      alog.delete();
      tick(); issue_d(7, 1'b1, 8'hFC, 2'b11, 1'b0, 64'd0, 1'b0, 1'b1, 64'h1122_3344_5566_7788, 7);
      wait_acks(7, 1);
      chk("dwl_nstrobes", 7, 64'(alog.size()), 64'd2);
      chk("dwl_addr0", 7, 64'(alog[0]), 64'hFC);
      chk("dwl_addr1", 7, 64'(alog[1]), 64'h00);

      rises0 = mov_rises;
      tick(); issue_d(8, 1'b1, 8'h31, 2'b01, 1'b0, 64'd0, 1'b1, 1'b1, 64'd0, 1);
      wait_acks(8, 1);
      tick(); issue_i(9, 8'h12, 1'b1, 64'd0, 1);
      wait_acks(9, 1);
      tick(); issue_d(10, 1'b0, 8'h22, 2'b10, 1'b0, 64'h0000_0000_1234_5678, 1'b1, 1'b0, 64'd0, 1);
      wait_acks(10, 1);
      chk("misalign_no_strobe", 10, 64'(mov_rises), 64'(rises0));

      moc_lat = 2;
      tick(); issue_d(11, 1'b1, 8'h10, 2'b10, 1'b0, 64'd0, 1'b0, 1'b1, 64'h0000_0000_DEAD_BEEF, 5);
      wait_acks(11, 1);
      moc_lat = 0;
      moc_en = 1'b0;
      tick(); issue_d(12, 1'b1, 8'h10, 2'b10, 1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 5);
      wait_acks(12, 1);
      moc_en = 1'b1;

      // Fresh reset so LastGrant is back at fetch and data wins the tie.
      tick(); Reset = 1'b1;
      tick(); Reset = 1'b0;
      tick();
      issue_d(13, 1'b1, 8'hFC, 2'b10, 1'b0, 64'd0, 1'b0, 1'b1, 64'h0000_0000_5566_7788, 4);
      issue_i(14, 8'h10, 1'b0, 64'h0000_0000_DEAD_BEEF, 9);
      wait_acks(14, 2);

      acks0 = dack_cnt + iack_cnt;
      tick();
      DReq = 1'b1; DRW = 1'b1; DAddr = 8'h10; DType = 2'b10; DSign = 1'b0;
      for (int k = 0; k < 10 && !MemMOV; k++) tick();
      chk("strobe_reached", 15, 64'(MemMOV), 64'd1);
      #2 Reset = 1'b1;
      #1;
      chk("rst_mov_async", 15, 64'(MemMOV), 64'd0);
      chk("rst_busy_async", 15, 64'(Busy), 64'd0);
      DReq = 1'b0;
      tick(); Reset = 1'b0;
      repeat (8) tick();
      chk("no_ack_after_rst", 15, 64'(dack_cnt + iack_cnt), 64'(acks0));
      chk("rw_after_rst", 15, 64'(MemRW), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
